// File: rtl/adc_scan_framer.sv
// Periodic multi-channel ADC scan sequencer that frames each sample as header + MSB-first bytes for a UART.
// Latency: scan starts the cycle after a tick; every byte costs at least SEND + GAP + TXW (>=3 cycles).
// Backpressure: each byte waits in TXW until tx_busy is low. Optional trailer checksum: define FRAME_CHECKSUM_EN.
module adc_scan_framer #(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 12,
  parameter int SCAN_DIV = 5000
) (
  input  logic                clk,
  input  logic                reset_N,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                adc_go,
  output logic [3:0]          adc_ch,
  input  logic                adc_done,
  input  logic [SAMPLE_W-1:0] adc_val,
  input  logic                tx_busy,
  output logic                new_data,
  output logic [7:0]          data_in,
  output logic                scan_done,
  output logic                overrun
);

  localparam int NBYTES = (SAMPLE_W + 7) / 8;
  localparam int SW     = NBYTES * 8;
  localparam int BW     = $clog2(NBYTES + 1);
  localparam int CW     = $clog2(SCAN_DIV);

  typedef enum logic [3:0] {
    IDLE, SELECT, CONV, WAIT_ADC, SEND, GAP, TXW,
`ifdef FRAME_CHECKSUM_EN
    TRAIL,
`endif
    FINISH
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic                tick;
  logic [NUM_CH-1:0]   mask_q;
  logic [4:0]          idx_q;      // one bit wider than adc_ch so idx can step past channel 15
  logic [SW-1:0]       sample_q;
  logic [BW-1:0]       b_q;
  logic                sel_found;
  logic [3:0]          sel_ch;
  logic [7:0]          nxt_byte;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]          chk_q;
  logic                trail_q;
`endif

  assign tick = enable && (cnt_q == CW'(SCAN_DIV - 1));

  // Scan-rate counter: free-runs while enabled, parked at zero otherwise
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)     cnt_q <= '0;
    else if (!enable) cnt_q <= '0;
    else if (tick)    cnt_q <= '0;
    else              cnt_q <= cnt_q + CW'(1);
  end

  // Sticky overrun: a tick that lands while a scan is still running is dropped and flagged
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N)                          overrun <= 1'b0;
    else if (!enable)                      overrun <= 1'b0;
    else if (tick && (state_q != IDLE))    overrun <= 1'b1;
  end

  // Lowest latched-mask channel at or above the current index
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i] && (i >= int'(idx_q))) begin
        sel_found = 1'b1;
        sel_ch    = 4'(i);
      end
    end
  end

  // Next data byte after header/byte b: bytes go out most significant first
  always_comb begin
    nxt_byte = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (b_q == BW'(NBYTES - 1 - k)) nxt_byte = sample_q[8*k +: 8];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and the single-cycle strobes, which are pure state decodes
  always_comb begin
    state_d   = state_q;
    adc_go    = 1'b0;
    new_data  = 1'b0;
    scan_done = 1'b0;
    case (state_q)
      IDLE:     if (tick && (ch_mask != '0)) state_d = SELECT;
      SELECT: begin
        if (sel_found) state_d = CONV;
`ifdef FRAME_CHECKSUM_EN
        else           state_d = TRAIL;
`else
        else           state_d = FINISH;
`endif
      end
      CONV: begin
        adc_go  = 1'b1;
        state_d = WAIT_ADC;
      end
      WAIT_ADC: if (adc_done) state_d = SEND;
      SEND: begin
        new_data = 1'b1;
        state_d  = GAP;
      end
      GAP:      state_d = TXW;
      TXW: begin
        if (!tx_busy) begin
`ifdef FRAME_CHECKSUM_EN
          if (trail_q)                         state_d = FINISH;
          else
`endif
          if (b_q != BW'(NBYTES))              state_d = SEND;
          else                                 state_d = SELECT;
        end
      end
`ifdef FRAME_CHECKSUM_EN
      TRAIL: begin
        new_data = 1'b1;
        state_d  = GAP;
      end
`endif
      FINISH: begin
        scan_done = 1'b1;
        state_d   = IDLE;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Scan datapath: mask latch, channel index, sample capture, byte sequencing
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      mask_q   <= '0;
      idx_q    <= '0;
      adc_ch   <= '0;
      sample_q <= '0;
      b_q      <= '0;
      data_in  <= '0;
`ifdef FRAME_CHECKSUM_EN
      chk_q    <= '0;
      trail_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (state_d == SELECT) begin
            mask_q <= ch_mask;
            idx_q  <= '0;
`ifdef FRAME_CHECKSUM_EN
            chk_q   <= '0;
            trail_q <= 1'b0;
`endif
          end
        end
        SELECT: begin
          if (sel_found) adc_ch <= sel_ch;
`ifdef FRAME_CHECKSUM_EN
          else begin
            data_in <= chk_q;
            trail_q <= 1'b1;
          end
`endif
        end
        WAIT_ADC: begin
          if (adc_done) begin
            sample_q <= SW'(adc_val);
            b_q      <= '0;
            data_in  <= {4'h8, adc_ch};
          end
        end
`ifdef FRAME_CHECKSUM_EN
        SEND:     chk_q <= chk_q ^ data_in;
`endif
        TXW: begin
`ifdef FRAME_CHECKSUM_EN
          if (!tx_busy && !trail_q) begin
`else
          if (!tx_busy) begin
`endif
            if (b_q != BW'(NBYTES)) begin
              b_q     <= b_q + BW'(1);
              data_in <= nxt_byte;
            end else begin
              idx_q   <= {1'b0, adc_ch} + 5'd1;
            end
          end
        end
        FINISH:   idx_q <= '0;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_framer.sv
// Directed bench for adc_scan_framer (NUM_CH=4, SAMPLE_W=12, SCAN_DIV=16).
// A frame-level model predicts each scan's byte stream and channel order; a negedge monitor compares.
// Literal byte lists pin the model for each scenario.
module tb_adc_scan_framer;
  localparam int NUM_CH   = 4;
  localparam int SAMPLE_W = 12;
  localparam int SCAN_DIV = 16;

  logic        clk = 1'b0;
  logic        reset_N = 1'b0;
  logic        enable = 1'b0;
  logic [3:0]  ch_mask = 4'b0;
  logic        adc_go;
  logic [3:0]  adc_ch;
  logic        adc_done = 1'b0;
  logic [11:0] adc_val = 12'h0;
  logic        tx_busy = 1'b0;
  logic        new_data;
  logic [7:0]  data_in;
  logic        scan_done;
  logic        overrun;

  always #5 clk = ~clk;

  adc_scan_framer #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .reset_N(reset_N), .enable(enable), .ch_mask(ch_mask),
    .adc_go(adc_go), .adc_ch(adc_ch), .adc_done(adc_done), .adc_val(adc_val),
    .tx_busy(tx_busy), .new_data(new_data), .data_in(data_in),
    .scan_done(scan_done), .overrun(overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int n_go = 0, n_nd = 0, n_done = 0;
  int last_nd_cyc = -1000;
  int min_gap = 3;
  int adc_delay = 2;
  int busy_len = 0;

  logic [11:0] vals [4];
  logic [7:0]  exp_q[$];
  logic [3:0]  exp_ch_q[$];
  logic [7:0]  got_q[$];
  logic [7:0]  lit_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Frame model: per masked channel ascending, header then sample bytes MSB first (+ XOR trailer)
  task automatic push_frame(input logic [3:0] m);
    logic [7:0]  x;
    logic [15:0] v;
    x = 8'h0;
    for (int c = 0; c < 4; c++) begin
      if (m[c]) begin
        v = {4'h0, vals[c]};
        exp_ch_q.push_back(4'(c));
        exp_q.push_back(8'h80 + 8'(c));
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
        x = x ^ (8'h80 + 8'(c)) ^ v[15:8] ^ v[7:0];
      end
    end
`ifdef FRAME_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  task automatic check_lit(input string nm);
    check({nm, "_len"}, 32'(got_q.size()), 32'(lit_q.size()));
    for (int i = 0; i < lit_q.size(); i++)
      check($sformatf("%s_b%0d", nm, i), (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF, 32'(lit_q[i]));
  endtask

  function automatic int cur(input int sel);
    if (sel == 0)      return n_go;
    else if (sel == 1) return n_nd;
    else               return n_done;
  endfunction

  task automatic wait_for(input int sel, input int target, input int budget, input string nm);
    int k;
    k = 0;
    while (k < budget && cur(sel) < target) begin
      @(posedge clk);
      k++;
    end
    check({nm, "_reached"}, 32'(cur(sel) >= target), 32'd1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every strobe against the model
  always @(negedge clk) begin
    if (reset_N) begin
      if (adc_go) begin
        n_go++;
        if (exp_ch_q.size() == 0) check("unexpected_adc_go", 32'd1, 32'd0);
        else                      check("adc_ch", 32'(adc_ch), 32'(exp_ch_q.pop_front()));
      end
      if (new_data) begin
        n_nd++;
        got_q.push_back(data_in);
        if (exp_q.size() == 0) check("unexpected_byte", 32'(data_in), 32'hFFFF);
        else                   check("byte", 32'(data_in), 32'(exp_q.pop_front()));
        check("byte_spacing_ok", 32'((cyc - last_nd_cyc) >= min_gap), 32'd1);
        last_nd_cyc = cyc;
      end
      if (scan_done) begin
        n_done++;
        check("frame_complete", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  // ADC model: answer each adc_go after adc_delay cycles with the table value
  initial begin : adc_model
    logic [3:0] ch;
    forever begin
      @(negedge clk);
      if (adc_go && reset_N) begin
        ch = adc_ch;
        repeat (adc_delay) @(negedge clk);
        adc_val  = vals[ch[1:0]];
        adc_done = 1'b1;
        @(negedge clk);
        adc_done = 1'b0;
      end
    end
  end

  // UART model: busy rises one cycle after new_data and lasts busy_len cycles
  initial begin : uart_model
    forever begin
      @(negedge clk);
      if (new_data && busy_len > 0) begin
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        tx_busy = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int g0, n0, d0;
    vals[0] = 12'h0; vals[1] = 12'h0; vals[2] = 12'h0; vals[3] = 12'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_adc_go", 32'(adc_go), 32'd0);
    check("rst_adc_ch", 32'(adc_ch), 32'd0);
    check("rst_new_data", 32'(new_data), 32'd0);
    check("rst_data_in", 32'(data_in), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    reset_N = 1'b1;

    // S1: single channel 2, idle UART; enable dropped mid-scan must not abort
    vals[2] = 12'hABC; busy_len = 0; min_gap = 3; ch_mask = 4'b0100;
    got_q.delete(); push_frame(4'b0100);
    g0 = n_go; d0 = n_done;
    @(negedge clk); enable = 1'b1;
    wait_for(0, g0 + 1, 60, "s1_start");
    @(negedge clk); enable = 1'b0;
    wait_for(2, d0 + 1, 80, "s1_done");
    @(negedge clk);
    check("s1_go_count", 32'(n_go - g0), 32'd1);
    lit_q = '{8'h82, 8'h0A, 8'hBC};
`ifdef FRAME_CHECKSUM_EN
    lit_q.push_back(8'h34);
`endif
    check_lit("s1");

    // S2: channels 0 and 3, slow UART; mask cleared mid-scan must not matter
    vals[0] = 12'h5A3; vals[3] = 12'hF0E; busy_len = 10; min_gap = 10; ch_mask = 4'b1001;
    got_q.delete(); push_frame(4'b1001);
    g0 = n_go; d0 = n_done;
    enable = 1'b1;
    wait_for(0, g0 + 1, 60, "s2_start");
    @(negedge clk); enable = 1'b0; ch_mask = 4'b0000;
    wait_for(2, d0 + 1, 400, "s2_done");
    @(negedge clk);
    check("s2_go_count", 32'(n_go - g0), 32'd2);
    lit_q = '{8'h80, 8'h05, 8'hA3, 8'h83, 8'h0F, 8'h0E};
`ifdef FRAME_CHECKSUM_EN
    lit_q.push_back(8'hA4);
`endif
    check_lit("s2");
    busy_len = 0; min_gap = 3;

    // S3: empty mask ignores ticks entirely
    ch_mask = 4'b0000; g0 = n_go; n0 = n_nd; d0 = n_done;
    enable = 1'b1;
    repeat (100) @(negedge clk);
    check("s3_no_go", 32'(n_go - g0), 32'd0);
    check("s3_no_byte", 32'(n_nd - n0), 32'd0);
    check("s3_no_done", 32'(n_done - d0), 32'd0);
    check("s3_overrun", 32'(overrun), 32'd0);
    enable = 1'b0;
    @(negedge clk);

    // S4: slow ADC causes overrun, scan still completes, disable clears it
    vals[0] = 12'h123; adc_delay = 40; ch_mask = 4'b0001;
    got_q.delete(); push_frame(4'b0001);
    d0 = n_done;
    enable = 1'b1;
    wait_for(2, d0 + 1, 200, "s4_done");
    @(negedge clk);
    check("s4_overrun_set", 32'(overrun), 32'd1);
    enable = 1'b0;
    @(negedge clk);
    check("s4_overrun_clear", 32'(overrun), 32'd0);
    lit_q = '{8'h80, 8'h01, 8'h23};
`ifdef FRAME_CHECKSUM_EN
    lit_q.push_back(8'hA2);
`endif
    check_lit("s4");
    adc_delay = 2;

    // S5: reset asserted while waiting on the UART
    vals[2] = 12'hABC; busy_len = 10; min_gap = 10; ch_mask = 4'b0100;
    got_q.delete(); push_frame(4'b0100);
    n0 = n_nd;
    enable = 1'b1;
    wait_for(1, n0 + 1, 60, "s5_first_byte");
    repeat (4) @(negedge clk);
    reset_N = 1'b0;
    #1;
    check("s5_rst_adc_go", 32'(adc_go), 32'd0);
    check("s5_rst_adc_ch", 32'(adc_ch), 32'd0);
    check("s5_rst_new_data", 32'(new_data), 32'd0);
    check("s5_rst_data_in", 32'(data_in), 32'd0);
    check("s5_rst_scan_done", 32'(scan_done), 32'd0);
    check("s5_rst_overrun", 32'(overrun), 32'd0);
    exp_q.delete(); exp_ch_q.delete();
    @(negedge clk); @(negedge clk);
    got_q.delete(); push_frame(4'b0100);
    n0 = n_nd; g0 = n_go; d0 = n_done;
    reset_N = 1'b1;
    repeat (16) @(negedge clk);
    check("s5_no_byte_before_tick", 32'(n_nd - n0), 32'd0);
    wait_for(0, g0 + 1, 60, "s5_restart");
    @(negedge clk); enable = 1'b0;
    wait_for(2, d0 + 1, 200, "s5_done");
    @(negedge clk);
    lit_q = '{8'h82, 8'h0A, 8'hBC};
`ifdef FRAME_CHECKSUM_EN
    lit_q.push_back(8'h34);
`endif
    check_lit("s5");

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
